// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit: opcodes and FSM states.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_arith_unit_if.sv
// Request/response bundle of the arithmetic unit.
//
// Handshake: start is a request level, accepted on any rising edge where the
// unit is ready (not busy: state IDLE or DONE). Operands and op are captured
// on that same edge and may change freely afterwards. done is a one-cycle
// pulse; result/carry/zero/err are valid from that cycle and hold until the
// next operation completes. state is a debug view of the control FSM.
interface seq_arith_unit_if #(parameter int N = 4);
    import arith_pkg::*;

    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           carry;
    logic           zero;
    logic           err;
    state_e         state;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, zero, err, state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, zero, err, state
    );

endinterface

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder; the single adder shared by every operation.
module rca_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Ripple the carry bit by bit from cin to cout.
    always_comb begin
        logic [N:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout = c[N];
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add / subtract / shift-and-add multiply around one shared adder.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_arith_unit_if.slave  bus
);

    localparam int CW = $clog2(N);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [N-1:0]    a_q, b_q;
    logic [2*N-1:0]  p_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  result_q;
    logic            carry_q, zero_q, err_q;

    logic            ready, accept, mul_last;
    logic [N-1:0]    add_x, add_y, add_sum;
    logic            add_cin, add_cout;
    logic [N:0]      upper;
    logic [2*N-1:0]  p_next;

    assign ready    = (state_q == IDLE) || (state_q == DONE);
    assign accept   = ready && bus.start;
    assign mul_last = (cnt_q == CW'(N - 1));

    // Adder operand mux: partial-product accumulate in MUL, a+b or a+~b+1 otherwise.
    always_comb begin
        add_x   = a_q;
        add_y   = b_q;
        add_cin = 1'b0;
        if (state_q == MUL) begin
            add_x = p_q[2*N-1:N];
            add_y = a_q;
        end else if (op_q == OP_SUB) begin
            add_y   = ~b_q;
            add_cin = 1'b1;
        end
    end

    rca_adder #(.N(N)) u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One shift-and-add step: add the multiplicand when the multiplier LSB is set, then shift right.
    always_comb begin
        upper  = p_q[0] ? {add_cout, add_sum} : {1'b0, p_q[2*N-1:N]};
        p_next = {upper, p_q[N-1:1]};
    end

    // Control FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = (op_e'(bus.op) == OP_MUL) ? MUL : EXEC;
                else
                    state_d = IDLE;
            end
            EXEC:    state_d = DONE;
            MUL:     state_d = mul_last ? DONE : MUL;
            default: state_d = IDLE;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, multiply iteration and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            op_q  <= op_e'(bus.op);
            a_q   <= bus.a;
            b_q   <= bus.b;
            p_q   <= {{N{1'b0}}, bus.b};
            cnt_q <= '0;
        end else if (state_q == EXEC) begin
            case (op_q)
                OP_ADD: begin
                    result_q <= {{(N-1){1'b0}}, add_cout, add_sum};
                    carry_q  <= add_cout;
                    zero_q   <= ({add_cout, add_sum} == '0);
                    err_q    <= 1'b0;
                end
                OP_SUB: begin
                    result_q <= {{N{1'b0}}, add_sum};
                    carry_q  <= ~add_cout;
                    zero_q   <= (add_sum == '0);
                    err_q    <= 1'b0;
                end
                default: begin
                    result_q <= '0;
                    carry_q  <= 1'b0;
                    zero_q   <= 1'b1;
                    err_q    <= 1'b1;
                end
            endcase
        end else if (state_q == MUL) begin
            p_q   <= p_next;
            cnt_q <= cnt_q + CW'(1);
            if (mul_last) begin
                result_q <= p_next;
                carry_q  <= 1'b0;
                zero_q   <= (p_next == '0);
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.busy   = (state_q == EXEC) || (state_q == MUL);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.err    = err_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed scoreboard bench for seq_arith_unit at N=4.
module tb_seq_arith_unit;
    import arith_pkg::*;

    localparam int N = 4;
    localparam int W = 2*N + 3;   // {result, carry, zero, err}

    logic clk;
    logic rst;

    seq_arith_unit_if #(.N(N)) bus ();

    seq_arith_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    logic prev_done = 1'b0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                check("done_not_consecutive", 16'(prev_done), 16'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: actual=done required=no_done");
                end else begin
                    e = exp_q.pop_front();
                    check("result", 16'(bus.result), 16'(e[W-1:3]));
                    check("carry",  16'(bus.carry),  16'(e[2]));
                    check("zero",   16'(bus.zero),   16'(e[1]));
                    check("err",    16'(bus.err),    16'(e[0]));
                end
            end
            prev_done = bus.done;
        end
    end

    // Wait (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(input int lat);
        int busy_cycles = 0;
        int n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk); #1;
            n++;
        end
        if (!bus.done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: actual=no_done required=done");
        end
        check("busy_cycles", 16'(busy_cycles), 16'(lat));
    endtask

    // Issue one operation and push its hand-computed response.
    task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] res, input logic c, input logic z, input logic e,
                         input int lat);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        exp_q.push_back({res, c, z, e});
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int done_cnt;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   16'(bus.busy),   16'd0);
        check("rst_done",   16'(bus.done),   16'd0);
        check("rst_result", 16'(bus.result), 16'd0);
        check("rst_carry",  16'(bus.carry),  16'd0);
        check("rst_zero",   16'(bus.zero),   16'd0);
        check("rst_err",    16'(bus.err),    16'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // add / sub
        do_op(2'b00, 4'd9,  4'd8,  8'h11, 1'b1, 1'b0, 1'b0, 1);
        do_op(2'b01, 4'd3,  4'd5,  8'h0E, 1'b1, 1'b0, 1'b0, 1);
        do_op(2'b01, 4'd5,  4'd5,  8'h00, 1'b0, 1'b1, 1'b0, 1);
        do_op(2'b00, 4'd15, 4'd15, 8'h1E, 1'b1, 1'b0, 1'b0, 1);
        do_op(2'b01, 4'd0,  4'd15, 8'h01, 1'b1, 1'b0, 1'b0, 1);
        @(posedge clk); #1;

        // multiply
        do_op(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 1'b0, 4);
        do_op(2'b10, 4'd0,  4'd13, 8'h00, 1'b0, 1'b1, 1'b0, 4);
        @(posedge clk); #1;

        // 6*7 with start re-asserted and operands changed mid-MUL; start held into DONE
        bus.op = 2'b10; bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
        exp_q.push_back({8'd42, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.op = 2'b00; bus.a = 4'd9; bus.b = 4'd9;
        exp_q.push_back({8'd3, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        bus.a = 4'd1; bus.b = 4'd2;
        wait_done(3);
        @(posedge clk); #1;
        check("b2b_busy", 16'(bus.busy), 16'd1);
        check("b2b_done", 16'(bus.done), 16'd0);
        bus.start = 1'b0;
        wait_done(1);
        @(posedge clk); #1;

        // reset in the second MUL cycle
        bus.op = 2'b10; bus.a = 4'd15; bus.b = 4'd15; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",   16'(bus.busy),   16'd0);
        check("midrst_done",   16'(bus.done),   16'd0);
        check("midrst_result", 16'(bus.result), 16'd0);
        check("midrst_carry",  16'(bus.carry),  16'd0);
        check("midrst_zero",   16'(bus.zero),   16'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", 16'(done_cnt), 16'd0);

        // reserved op, then add clears err
        do_op(2'b11, 4'd7, 4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1);
        @(posedge clk); #1;
        check("rsv_err_hold", 16'(bus.err), 16'd1);
        do_op(2'b00, 4'd1, 4'd2, 8'h03, 1'b0, 1'b0, 1'b0, 1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
